// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
//   I2S transmitter fed from a 2-entry stereo FIFO. Incoming words are
//   saturated to SAMPLE_BITS signed on write. Each frame is serialized MSB
//   first with the standard I2S one-bit delay: the LSB of a right sample goes
//   out in slot 0 of the following frame.
//
//   Parameters
//     DATA_WIDTH  : width of the incoming signed audio words (must exceed SAMPLE_BITS)
//     SAMPLE_BITS : width of each serialized sample
//     BCLK_DIV    : system clocks per bclk half-period (1..255)
//
//   Ports
//     clock, reset    : system clock, asynchronous active-high reset
//     en              : transmit enable, only looked at on frame boundaries
//     left_in/right_in: stereo pair, accepted when in_valid && in_ready
//     in_ready        : FIFO has room (from the registered count)
//     bclk/lrclk/sdata: I2S bit clock, word select (0 = left) and data
//     underrun_count  : frames sent with nothing queued, saturating
module audio_i2s_tx #(
    parameter int DATA_WIDTH  = 32,
    parameter int SAMPLE_BITS = 16,
    parameter int BCLK_DIV    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] left_in,
    input  logic [DATA_WIDTH-1:0] right_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic [15:0]           underrun_count
);

    localparam int FRAME_SLOTS = 2 * SAMPLE_BITS;
    localparam int SLOT_W      = $clog2(FRAME_SLOTS);
    localparam int PAIR_W      = 2 * SAMPLE_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    // Clamp a signed input word into the signed SAMPLE_BITS range. The word is
    // in range exactly when every bit from the sample sign bit upward matches.
    function automatic logic [SAMPLE_BITS-1:0] saturate(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-SAMPLE_BITS:0] top;
        top = w[DATA_WIDTH-1:SAMPLE_BITS-1];
        if (top == '0 || top == '1)
            return w[SAMPLE_BITS-1:0];
        else if (w[DATA_WIDTH-1])
            return {1'b1, {(SAMPLE_BITS-1){1'b0}}};
        else
            return {1'b0, {(SAMPLE_BITS-1){1'b1}}};
    endfunction

    logic [PAIR_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [PAIR_W-1:0] fifo_head;

    logic [7:0]        div_cnt;
    logic [SLOT_W-1:0] slot_cnt;
    logic [PAIR_W-1:0] shift_reg;
    logic              stopping;
    logic              div_wrap;
    logic              slot_end;
    logic              frame_end;
    logic              start;
    logic              underrun_inc;

    assign fifo_empty = (fifo_count == 2'd0);
    assign in_ready   = (fifo_count != 2'd2);
    assign push       = in_valid && in_ready;
    assign fifo_head  = fifo_mem[rd_ptr];

    // A bit slot ends on the bclk 1->0 transition; the frame ends when that
    // happens in the last slot.
    assign div_wrap  = (state == RUN) && (div_cnt == 8'(BCLK_DIV - 1));
    assign slot_end  = div_wrap && bclk;
    assign frame_end = slot_end && (slot_cnt == SLOT_W'(FRAME_SLOTS - 1));

    // FIFO storage holds already-saturated samples, left in the upper half,
    // so the head can be loaded straight into the shifter.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= {saturate(left_in), saturate(right_in)};
    end

    // FIFO pointers and occupancy; push and pop in the same cycle cancel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state: leave IDLE only when there is something to send, and drop
    // back once the trailing slot 0 of a stopping frame has finished.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (en && !fifo_empty) state_next = RUN;
            RUN:  if (slot_end && stopping) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame-boundary decisions: pop a pair, or count an underrun frame.
    always_comb begin
        start        = 1'b0;
        pop          = 1'b0;
        underrun_inc = 1'b0;
        case (state)
            IDLE: begin
                if (en && !fifo_empty) begin
                    start = 1'b1;
                    pop   = 1'b1;
                end
            end
            RUN: begin
                if (frame_end && en) begin
                    if (!fifo_empty)
                        pop = 1'b1;
                    else
                        underrun_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Serializer. At every slot start sdata takes the shifter MSB; after the
    // 2S-1 shifts of a frame the MSB is the right LSB, which is exactly what
    // slot 0 of the next frame must carry, so the boundary needs no special
    // case beyond reloading the shifter. Leaving IDLE always sends 0 in slot 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            sdata     <= 1'b0;
            slot_cnt  <= '0;
            shift_reg <= '0;
            stopping  <= 1'b0;
        end else if (start) begin
            div_cnt   <= '0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            sdata     <= 1'b0;
            slot_cnt  <= '0;
            shift_reg <= fifo_head;
            stopping  <= 1'b0;
        end else if (state == RUN) begin
            if (slot_end && stopping) begin
                div_cnt   <= '0;
                bclk      <= 1'b0;
                lrclk     <= 1'b0;
                sdata     <= 1'b0;
                slot_cnt  <= '0;
                shift_reg <= '0;
                stopping  <= 1'b0;
            end else begin
                if (div_wrap) begin
                    div_cnt <= '0;
                    bclk    <= ~bclk;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
                if (slot_end) begin
                    sdata <= shift_reg[PAIR_W-1];
                    if (frame_end) begin
                        slot_cnt  <= '0;
                        lrclk     <= 1'b0;
                        stopping  <= !en;
                        shift_reg <= pop ? fifo_head : '0;
                    end else begin
                        slot_cnt  <= slot_cnt + SLOT_W'(1);
                        shift_reg <= {shift_reg[PAIR_W-2:0], 1'b0};
                        if (slot_cnt == SLOT_W'(SAMPLE_BITS - 1))
                            lrclk <= 1'b1;
                    end
                end
            end
        end
    end

    // Saturating underrun counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            underrun_count <= 16'd0;
        else if (underrun_inc && underrun_count != 16'hFFFF)
            underrun_count <= underrun_count + 16'd1;
    end

endmodule
